and_tree_glitch_filter: RTL and testbench
=========================================

// Module: and_tree_glitch_filter
// PURPOSE
// - Downstream consumer of the combinational AND-tree stage (out = (a&b)&(c&d)).
// - The AND tree has unequal per-gate delays (5/7/4), so its output can glitch
//   when inputs change.
// - This block synchronises that raw output into the clk domain and rejects pulses
//   shorter than STABLE_CYCLES. It emits a clean level plus one-cycle rise/fall
//   strobes, and keeps a saturating count of rejected glitches.
// PARAMETERS
// - SYNC_STAGES    2  flops in the input synchroniser chain; legal range >= 2
// - STABLE_CYCLES  4  consecutive differing samples needed to accept a new level; >= 1
// - CNT_W          8  width of glitch_cnt
// PORTS
// - clk         in   1      single clock; all state on rising edge
// - rst_n       in   1      asynchronous, active-low reset
// - din         in   1      raw, asynchronous AND-tree output
// - clr_cnt     in   1      synchronous clear of glitch_cnt
// - dout        out  1      filtered level (registered)
// - rise        out  1      1-cycle strobe, same edge dout goes 0->1
// - fall        out  1      1-cycle strobe, same edge dout goes 1->0
// - busy        out  1      high while a candidate level change is being qualified
// - glitch_cnt  out  CNT_W  number of rejected transitions; saturates at all-ones
// BEHAVIOUR
// - Reset (async assert, sync-style release by rst_n): the sync chain, dout, rise,
//   fall, busy, glitch_cnt, run counter and state all go to 0 / STABLE, immediately
//   and regardless of clk. Reset mid-qualification discards the candidate and does
//   not count a glitch.
// - Sync: s = last flop of the SYNC_STAGES chain; din is captured by flop 1 only.
// - Run counter: run, width clog2(STABLE_CYCLES)+1.
// - FSM, evaluated each edge:
//   - STABLE:
//     - if s == dout: hold.
//     - if s != dout and STABLE_CYCLES == 1: dout <= s, strobe.
//     - if s != dout otherwise: run <= 1, go to QUALIFY.
//   - QUALIFY:
//     - if s == dout: glitch; glitch_cnt += 1 (saturating), run <= 0, go to STABLE.
//     - else if run == STABLE_CYCLES-1: dout <= s, pulse rise or fall, run <= 0,
//       go to STABLE.
//     - else: run <= run + 1.
// - busy = (state == QUALIFY). It is registered with the state.
// - rise/fall are high for exactly one cycle and never both high. They are 0 on
//   every cycle with no dout change.
// - Latency: call the first edge that samples a changed din edge 1. dout changes
//   on edge SYNC_STAGES + STABLE_CYCLES (6 with defaults).
// - Minimum accepted pulse: STABLE_CYCLES clk periods at s. Shorter pulses are
//   counted as glitches; pulses shorter than 1 period may be missed entirely.
// - glitch_cnt:
//   - Saturates at 2^CNT_W-1; further glitches leave it unchanged.
//   - clr_cnt=1 -> glitch_cnt <= 0 on that edge. clr_cnt wins over a simultaneous
//     glitch increment.
// - After reset with din held 1: treated as a real edge. rise pulses at edge
//   SYNC_STAGES+STABLE_CYCLES after rst_n deasserts.
// - The FSM has no illegal reachable states. Any unused encoding -> STABLE
//   with run = 0.
// STRUCTURE
// - Package and_tree_pkg:
//   - state typedef {STABLE, QUALIFY}
//   - default constants AT_SYNC_STAGES=2, AT_STABLE_CYCLES=4, AT_CNT_W=8
// - Sub-module sync_chain #(STAGES) (clk, rst_n, d, q): N-flop synchroniser,
//   reset to 0. Reusable by other async inputs.
// - Top: FSM + run counter + glitch counter + strobe registers. No combinational
//   path from din to any output.
// TESTING
// - Reset: din=1, rst_n low for 3 cycles -> all outputs 0 during reset. Release ->
//   rise=1 on edge 6 only, dout=1 from then on.
// - Clean step: din 0->1 held 10 cycles -> dout rises on edge 6, rise high 1 cycle,
//   busy high on edges 3..5, glitch_cnt stays 0. Then din 1->0 -> fall on edge 6.
// - Glitch: din high 2 cycles then low -> dout stays 0, no rise, glitch_cnt=1,
//   busy returns 0.
// - Sub-cycle glitch: din high 3 ns inside one 10 ns period, not spanning an edge ->
//   no change on any output.
// - Saturation/clear: CNT_W=2, 5 glitches -> glitch_cnt=3. A glitch on the same
//   edge as clr_cnt=1 -> glitch_cnt=0.
// - Reset mid-QUALIFY: din high, assert rst_n at edge 4 -> outputs 0 immediately,
//   glitch_cnt=0. After release with din still high, rise appears on edge 6.

Source files
------------

// File: rtl/and_tree_pkg.sv
// Shared types and default constants for the AND-tree glitch filter.
package and_tree_pkg;

  typedef enum logic [0:0] {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } state_t;

  localparam int unsigned AT_SYNC_STAGES   = 2;
  localparam int unsigned AT_STABLE_CYCLES = 4;
  localparam int unsigned AT_CNT_W         = 8;

endpackage

// File: rtl/sync_chain.sv
// N-flop synchroniser for an asynchronous single-bit input; resets to 0.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the raw input through the chain; only ff[0] sees d directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/and_tree_glitch_filter.sv
// Synchronises the raw AND-tree output, rejects short pulses, emits a clean
// level with rise/fall strobes and counts rejected glitches (saturating).
module and_tree_glitch_filter
  import and_tree_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = AT_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = AT_STABLE_CYCLES,
  parameter int unsigned CNT_W         = AT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam int unsigned      RUN_W    = $clog2(STABLE_CYCLES) + 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);

  logic             s;
  state_t           state, state_nxt;
  logic [RUN_W-1:0] run, run_nxt;
  logic             dout_nxt, rise_nxt, fall_nxt, busy_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             glitch;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din),
    .q     (s)
  );

  // State, run counter, filtered level, strobes and glitch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= STABLE;
      run        <= '0;
      dout       <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      busy       <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state      <= state_nxt;
      run        <= run_nxt;
      dout       <= dout_nxt;
      rise       <= rise_nxt;
      fall       <= fall_nxt;
      busy       <= busy_nxt;
      glitch_cnt <= cnt_nxt;
    end
  end

  // Qualify a candidate level: accept after STABLE_CYCLES differing samples,
  // otherwise drop back to STABLE and record a glitch.
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    dout_nxt  = dout;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    glitch    = 1'b0;

    case (state)
      STABLE: begin
        if (s != dout) begin
          if (STABLE_CYCLES == 1) begin
            dout_nxt = s;
            rise_nxt = s;
            fall_nxt = ~s;
            run_nxt  = '0;
          end else begin
            run_nxt   = RUN_W'(1);
            state_nxt = QUALIFY;
          end
        end
      end
      QUALIFY: begin
        if (s == dout) begin
          glitch    = 1'b1;
          run_nxt   = '0;
          state_nxt = STABLE;
        end else if (run == RUN_LAST) begin
          dout_nxt  = s;
          rise_nxt  = s;
          fall_nxt  = ~s;
          run_nxt   = '0;
          state_nxt = STABLE;
        end else begin
          run_nxt = run + RUN_W'(1);
        end
      end
      default: begin
        state_nxt = STABLE;
        run_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt == QUALIFY);

    // Clear has priority over a same-edge glitch; count saturates at all-ones.
    cnt_nxt = glitch_cnt;
    if (clr_cnt) begin
      cnt_nxt = '0;
    end else if (glitch && (glitch_cnt != {CNT_W{1'b1}})) begin
      cnt_nxt = glitch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_and_tree_glitch_filter.sv
// Directed bench for and_tree_glitch_filter: stimulus pushes the expected
// post-edge outputs, a monitor pops and compares on each falling edge.
module tb_and_tree_glitch_filter;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       clr_cnt;
  logic       dout, rise, fall, busy;
  logic [7:0] glitch_cnt;
  logic       dout2, rise2, fall2, busy2;
  logic [1:0] glitch_cnt2;

  typedef struct {
    logic  dout;
    logic  rise;
    logic  fall;
    logic  busy;
    int    cnt;
    int    cnt2;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;

  and_tree_glitch_filter u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .clr_cnt    (clr_cnt),
    .dout       (dout),
    .rise       (rise),
    .fall       (fall),
    .busy       (busy),
    .glitch_cnt (glitch_cnt)
  );

  // Narrow-counter instance for saturation checks; shares all stimulus.
  and_tree_glitch_filter #(.CNT_W(2)) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .clr_cnt    (clr_cnt),
    .dout       (dout2),
    .rise       (rise2),
    .fall       (fall2),
    .busy       (busy2),
    .glitch_cnt (glitch_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs for the next edge, then record what must follow that edge.
  task automatic tick(input logic d, input logic clr, input logic ed,
                      input logic er, input logic ef, input logic eb,
                      input int c1, input int c2, input string tag);
    exp_t e;
    din     = d;
    clr_cnt = clr;
    @(posedge clk);
    #1;
    e.dout = ed; e.rise = er; e.fall = ef; e.busy = eb;
    e.cnt  = c1; e.cnt2 = c2; e.tag = tag;
    sb.push_back(e);
  endtask

  // Held level change from 'from' to 'lvl': busy on edges 3..5, strobe on 6.
  task automatic step_seq(input logic lvl, input logic from, input int c1,
                          input int c2, input string tag);
    for (int k = 1; k <= 10; k++) begin
      if (k <= 2)      tick(lvl, 1'b0, from, 1'b0, 1'b0, 1'b0, c1, c2, tag);
      else if (k <= 5) tick(lvl, 1'b0, from, 1'b0, 1'b0, 1'b1, c1, c2, tag);
      else if (k == 6) tick(lvl, 1'b0, lvl, lvl, ~lvl, 1'b0, c1, c2, tag);
      else             tick(lvl, 1'b0, lvl, 1'b0, 1'b0, 1'b0, c1, c2, tag);
    end
  endtask

  // Two-cycle high pulse from dout=0; rejected on edge 5 (optionally with clr).
  task automatic glitch_seq(input logic clr5, input int c1b, input int c2b,
                            input int c1a, input int c2a, input string tag);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c1b, c2b, tag);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c1b, c2b, tag);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c1b, c2b, tag);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c1b, c2b, tag);
    tick(1'b0, clr5, 1'b0, 1'b0, 1'b0, 1'b0, c1a, c2a, tag);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c1a, c2a, tag);
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        nvec++;
        if (dout !== e.dout || rise !== e.rise || fall !== e.fall ||
            busy !== e.busy || glitch_cnt !== 8'(e.cnt) ||
            glitch_cnt2 !== 2'(e.cnt2) || rise2 !== e.rise ||
            fall2 !== e.fall || dout2 !== e.dout) begin
          nmis++;
          $display("FAIL %s @%0t: got dout=%b rise=%b fall=%b busy=%b cnt=%0d cnt2=%0d, need dout=%b rise=%b fall=%b busy=%b cnt=%0d cnt2=%0d",
                   e.tag, $time, dout, rise, fall, busy, glitch_cnt, glitch_cnt2,
                   e.dout, e.rise, e.fall, e.busy, e.cnt, e.cnt2);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    din     = 1'b1;
    clr_cnt = 1'b0;

    // Reset held with din high: everything stays 0.
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "reset_hold");
    rst_n = 1'b1;
    step_seq(1'b1, 1'b0, 0, 0, "reset_release");

    // Clean steps in both directions.
    step_seq(1'b0, 1'b1, 0, 0, "clean_fall");
    step_seq(1'b1, 1'b0, 0, 0, "clean_rise");
    step_seq(1'b0, 1'b1, 0, 0, "clean_fall2");

    // Short pulse rejected.
    glitch_seq(1'b0, 0, 0, 1, 1, "glitch");

    // Sub-cycle pulse between edges: invisible.
    #2 din = 1'b1;
    #3 din = 1'b0;
    repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, "subcycle");

    // Five more glitches: narrow counter saturates at 3.
    glitch_seq(1'b0, 1, 1, 2, 2, "sat1");
    glitch_seq(1'b0, 2, 2, 3, 3, "sat2");
    glitch_seq(1'b0, 3, 3, 4, 3, "sat3");
    glitch_seq(1'b0, 4, 3, 5, 3, "sat4");
    glitch_seq(1'b0, 5, 3, 6, 3, "sat5");

    // Reset pulse between edges while qualifying; din stays high.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6, 3, "rmq_pre");
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6, 3, "rmq_pre");
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6, 3, "rmq_pre");
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6, 3, "rmq_pre");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step_seq(1'b1, 1'b0, 0, 0, "rmq_release");

    // Clear beats a same-edge glitch.
    step_seq(1'b0, 1'b1, 0, 0, "fall3");
    glitch_seq(1'b0, 0, 0, 1, 1, "glitch_pre_clr");
    glitch_seq(1'b1, 1, 1, 0, 0, "clr_vs_glitch");

    din = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      nmis++;
      $display("FAIL drain: %0d expectations left, need 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
